regfile_writeback_queue: RTL and testbench

- Write-side front end for the 32x32 general-purpose register file: buffers execution results and issues them as register-file writes.
- Accepts results from the ALU/load path over a valid/ready handshake and queues up to DEPTH pending writes.
- Drains at most one write per cycle into the register file's single write port when granted.
- Forwards the youngest pending value to the two read ports so readers never see stale data.

---
 rtl/regfile_writeback_queue.sv | 111 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the 32x32 register file: buffers results, drains one write
// per granted cycle in push order, and forwards the youngest pending value to both read ports.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       wb_grant,
  output logic                       wb_we,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  input  logic [ADDR_W-1:0]          lookup_reg1,
  input  logic [ADDR_W-1:0]          lookup_reg2,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic push;
  logic enq;
  logic pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;

  // A handshake to x0 completes but never occupies an entry.
  assign push = in_valid && in_ready && !flush;
  assign enq  = push && (in_rd != '0);

  assign wb_we   = !empty && wb_grant && !flush;
  assign pop     = wb_we;
  assign wb_addr = empty ? '0 : ent_rd[rd_ptr];
  assign wb_data = empty ? '0 : ent_data[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (enq) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (enq && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !enq) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_rd[wr_ptr]   <= in_rd;
      ent_data[wr_ptr] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[rd_ptr + PTR_W'(i)] && (lookup_reg1 != '0) &&
          (ent_rd[rd_ptr + PTR_W'(i)] == lookup_reg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[rd_ptr + PTR_W'(i)];
      end
      if (ent_valid[rd_ptr + PTR_W'(i)] && (lookup_reg2 != '0) &&
          (ent_rd[rd_ptr + PTR_W'(i)] == lookup_reg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[rd_ptr + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: scoreboard of expected register-file
// writes checked by a monitor, plus per-scenario inline checks.
module tb_regfile_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              wb_grant;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] lookup_reg1;
  logic [ADDR_W-1:0] lookup_reg2;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  int tests_run = 0;
  int failed    = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_grant(wb_grant), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after posedge, so the negedge value of wb_we/addr/data is
  // what the register file captures at the following posedge.
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", wb_addr, wb_data);
      end else begin
        if ({wb_addr, wb_data} !== exp_q[0]) begin
          failed++;
          $display("FAIL wb_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   wb_addr, wb_data, exp_q[0][ADDR_W+DATA_W-1:DATA_W], exp_q[0][DATA_W-1:0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One-cycle push; caller guarantees the queue is not full and flush is low.
  task automatic push_one(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = d;
    if (rd != '0) exp_q.push_back({rd, d});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
    wb_grant = 1'b1; lookup_reg1 = '0; lookup_reg2 = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    settle();
    tests_run++;
    if ({in_ready, wb_we, count, empty, full} !== {1'b1, 1'b0, CNT_W'(0), 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL reset_state: got rdy=%b we=%b cnt=%0d empty=%b full=%b, required 1 0 0 1 0",
               in_ready, wb_we, count, empty, full);
    end
    lookup_reg1 = 5'd1; lookup_reg2 = 5'd2;
    settle();
    tests_run++;
    if ({wb_addr, wb_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got addr=%0d data=%h hit1=%b d1=%h hit2=%b d2=%h, required all 0",
               wb_addr, wb_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    end
  endtask

  task automatic test_single();
    wb_grant = 1'b1;
    push_one(5'd5, 32'hDEADBEEF);
    settle();
    tests_run++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      failed++;
      $display("FAIL single_head: got we=%b addr=%0d data=%h, required 1 5 deadbeef",
               wb_we, wb_addr, wb_data);
    end
    tick();
    tests_run++;
    if ({count, empty, wb_we} !== {CNT_W'(0), 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL single_drained: got cnt=%0d empty=%b we=%b, required 0 1 0", count, empty, wb_we);
    end
  endtask

  task automatic test_fill_drain();
    wb_grant = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(ADDR_W'(i), DATA_W'(i * 32'h11));
    tests_run++;
    if ({full, in_ready, count} !== {1'b1, 1'b0, CNT_W'(4)}) begin
      failed++;
      $display("FAIL fill_full: got full=%b rdy=%b cnt=%0d, required 1 0 4", full, in_ready, count);
    end
    // Offer a fifth result while full: it must not be taken.
    in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h99;
    tick();
    tests_run++;
    if (count !== CNT_W'(4)) begin
      failed++;
      $display("FAIL fill_overflow: got cnt=%0d, required 4", count);
    end
    wb_grant = 1'b1;
    settle();
    tests_run++;
    if ({in_ready, wb_we, wb_addr} !== {1'b0, 1'b1, 5'd1}) begin
      failed++;
      $display("FAIL full_no_passthru: got rdy=%b we=%b addr=%0d, required 0 1 1", in_ready, wb_we, wb_addr);
    end
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      tests_run++;
      if ({wb_we, wb_addr, wb_data} !== {1'b1, ADDR_W'(i), DATA_W'(i * 32'h11)}) begin
        failed++;
        $display("FAIL drain_%0d: got we=%b addr=%0d data=%h, required 1 %0d %h",
                 i, wb_we, wb_addr, wb_data, i, i * 32'h11);
      end
      tick();
    end
    tests_run++;
    if ({count, empty} !== {CNT_W'(0), 1'b1}) begin
      failed++;
      $display("FAIL drain_empty: got cnt=%0d empty=%b, required 0 1", count, empty);
    end
  endtask

  task automatic test_back_to_back();
    wb_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_one(ADDR_W'(10 + i), 32'hB000_0000 + DATA_W'(i));
      tests_run++;
      if (count !== CNT_W'(1)) begin
        failed++;
        $display("FAIL b2b_count_%0d: got cnt=%0d, required 1", i, count);
      end
    end
    tick();
    tests_run++;
    if (count !== CNT_W'(0)) begin
      failed++;
      $display("FAIL b2b_final: got cnt=%0d, required 0", count);
    end
  endtask

  task automatic test_forward();
    wb_grant = 1'b0;
    push_one(5'd7, 32'hA);
    push_one(5'd7, 32'hB);
    push_one(5'd12, 32'hC);
    lookup_reg1 = 5'd7; lookup_reg2 = 5'd0;
    settle();
    tests_run++;
    if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 32'hB, 1'b0, 32'h0}) begin
      failed++;
      $display("FAIL fwd_youngest: got hit1=%b d1=%h hit2=%b d2=%h, required 1 b 0 0",
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    end
    lookup_reg1 = 5'd12; lookup_reg2 = 5'd9;
    settle();
    tests_run++;
    if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {1'b1, 32'hC, 1'b0, 32'h0}) begin
      failed++;
      $display("FAIL fwd_other: got hit1=%b d1=%h hit2=%b d2=%h, required 1 c 0 0",
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    end
    // Drain 7/A and 7/B; during the cycle 7/B is written it is still forwarded.
    wb_grant = 1'b1; lookup_reg1 = 5'd7;
    tick();
    settle();
    tests_run++;
    if ({wb_we, wb_data, fwd_hit1, fwd_data1} !== {1'b1, 32'hB, 1'b1, 32'hB}) begin
      failed++;
      $display("FAIL fwd_head: got we=%b wdata=%h hit1=%b d1=%h, required 1 b 1 b",
               wb_we, wb_data, fwd_hit1, fwd_data1);
    end
    tick();
    settle();
    tests_run++;
    if ({fwd_hit1, fwd_data1} !== {1'b0, 32'h0}) begin
      failed++;
      $display("FAIL fwd_retired: got hit1=%b d1=%h, required 0 0", fwd_hit1, fwd_data1);
    end
    tick();
    lookup_reg1 = '0; lookup_reg2 = '0;
  endtask

  task automatic test_x0();
    wb_grant = 1'b1;
    settle();
    tests_run++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL x0_ready: got rdy=%b, required 1", in_ready);
    end
    push_one(5'd0, 32'hFFFFFFFF);
    settle();
    tests_run++;
    if ({count, wb_we} !== {CNT_W'(0), 1'b0}) begin
      failed++;
      $display("FAIL x0_discard: got cnt=%0d we=%b, required 0 0", count, wb_we);
    end
  endtask

  task automatic test_flush();
    wb_grant = 1'b0;
    push_one(5'd20, 32'h20);
    push_one(5'd21, 32'h21);
    tests_run++;
    if (count !== CNT_W'(2)) begin
      failed++;
      $display("FAIL flush_pre: got cnt=%0d, required 2", count);
    end
    flush = 1'b1; wb_grant = 1'b1;
    in_valid = 1'b1; in_rd = 5'd3; in_data = 32'h33;
    settle();
    tests_run++;
    if (wb_we !== 1'b0) begin
      failed++;
      $display("FAIL flush_we: got we=%b, required 0", wb_we);
    end
    tick();
    exp_q.delete();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if ({count, empty} !== {CNT_W'(0), 1'b1}) begin
      failed++;
      $display("FAIL flush_cleared: got cnt=%0d empty=%b, required 0 1", count, empty);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    wb_grant = 1'b0;
    push_one(5'd1, 32'h1);
    push_one(5'd2, 32'h2);
    push_one(5'd3, 32'h3);
    tests_run++;
    if (count !== CNT_W'(3)) begin
      failed++;
      $display("FAIL rstmid_pre: got cnt=%0d, required 3", count);
    end
    wb_grant = 1'b1;
    reset_n  = 1'b0;
    exp_q.delete();
    settle();
    tests_run++;
    if ({count, wb_we, empty} !== {CNT_W'(0), 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL rstmid_clear: got cnt=%0d we=%b empty=%b, required 0 0 1", count, wb_we, empty);
    end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_forward();
    test_x0();
    test_flush();
    test_reset_mid();
    repeat (2) tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL sb_leftover: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
